nn_perceptron_seq: RTL and testbench

Time-multiplexed, parametrised successor to the fully parallel perceptron.
- Computes data_o = act(sat(round(sum(weights[i]*data_i[i]) + bias))) using LANES multipliers over ceil(FEATURES/LANES) accumulate cycles.
- Adds valid/ready handshakes on both sides, round-to-nearest, saturation with a flag, and optional ReLU.
- Sits between layer-input buffering and the next layer in the nn/ datapath.

---
 rtl/nn_perceptron_seq_pkg.sv | 23 ++
 rtl/nn_round_sat.sv | 40 ++++
 rtl/nn_perceptron_seq.sv | 131 +++++++++++++
 tb/tb_nn_perceptron_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_perceptron_seq_pkg.sv
// Shared fixed-point types for the nn/ datapath.
// Q(INT_BITS).(FRAC_BITS) signed data and activation selection.
package nn_perceptron_seq_pkg;

  localparam int INT_BITS   = 8;
  localparam int FRAC_BITS  = 8;
  localparam int DATA_WIDTH = INT_BITS + FRAC_BITS;

  typedef logic signed [DATA_WIDTH-1:0] nn_data_t;

  typedef enum logic {
    ACT_NONE = 1'b0,
    ACT_RELU = 1'b1
  } nn_act_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINISH,
    ST_OUT
  } nn_state_e;

endpackage

// File: rtl/nn_round_sat.sv
// Wide accumulator + bias to nn_data_t: round half up,
// clip to the representable range and flag clipping.
module nn_round_sat
  import nn_perceptron_seq_pkg::*;
#(
  parameter int ACC_W = 37
) (
  input  logic signed [ACC_W-1:0] acc,
  input  nn_data_t                bias,
  output nn_data_t                data,
  output logic                    sat
);

  localparam int T_W = ACC_W + 1;

  localparam logic signed [T_W-1:0] MAX_V =
    (T_W'(1) <<< (DATA_WIDTH-1)) - T_W'(1);
  localparam logic signed [T_W-1:0] MIN_V =
    -(T_W'(1) <<< (DATA_WIDTH-1));

  logic signed [T_W-1:0] t;
  logic signed [T_W-1:0] r;

  always_comb begin
    t = T_W'(acc)
      + (T_W'(bias) <<< FRAC_BITS)
      + (T_W'(1) <<< (FRAC_BITS-1));
    r = t >>> FRAC_BITS;
    data = r[DATA_WIDTH-1:0];
    sat  = 1'b0;
    if (r > MAX_V) begin
      data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (r < MIN_V) begin
      data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/nn_perceptron_seq.sv
// Time-multiplexed perceptron: LANES MACs per cycle,
// valid/ready on both sides, rounding, saturation, optional ReLU.
module nn_perceptron_seq
  import nn_perceptron_seq_pkg::*;
#(
  parameter int FEATURES   = 11,
  parameter int LANES      = 4,
  parameter int ACTIVATION = 0,
  localparam int PASSES    = (FEATURES + LANES - 1) / LANES,
  localparam int ACC_W     =
    2*DATA_WIDTH + $clog2(FEATURES+1) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [FEATURES-1:0][DATA_WIDTH-1:0]  weights,
  input  logic [DATA_WIDTH-1:0]                bias,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FEATURES-1:0][DATA_WIDTH-1:0]  data_i,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic                                 sat_o
);

  localparam int PAD    = PASSES * LANES;
  localparam int SH_W   = PAD * DATA_WIDTH;
  localparam int PC_W   = $clog2(PASSES + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  nn_state_e                state;
  logic [SH_W-1:0]          w_sh;
  logic [SH_W-1:0]          x_sh;
  nn_data_t                 b_q;
  logic [PC_W-1:0]          pass_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  psum_q;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  prod [LANES];
  nn_data_t                 rs_data;
  logic                     rs_sat;

  // Operands shift down by LANES each pass; lanes see the low slots.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    nn_data_t                w_l;
    nn_data_t                x_l;
    logic signed [PROD_W-1:0] p_l;
    assign w_l     = w_sh[l*DATA_WIDTH +: DATA_WIDTH];
    assign x_l     = x_sh[l*DATA_WIDTH +: DATA_WIDTH];
    assign p_l     = PROD_W'(w_l) * PROD_W'(x_l);
    assign prod[l] = ACC_W'(p_l);
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + prod[l];
    end
  end

  nn_round_sat #(
    .ACC_W (ACC_W)
  ) u_round_sat (
    .acc  (acc_q),
    .bias (b_q),
    .data (rs_data),
    .sat  (rs_sat)
  );

  // Lane sums are registered; the extra pass at PASSES drains them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_o    <= '0;
      sat_o     <= 1'b0;
      acc_q     <= '0;
      psum_q    <= '0;
      pass_q    <= '0;
      w_sh      <= '0;
      x_sh      <= '0;
      b_q       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            w_sh     <= SH_W'(weights);
            x_sh     <= SH_W'(data_i);
            b_q      <= bias;
            acc_q    <= '0;
            psum_q   <= '0;
            pass_q   <= '0;
            in_ready <= 1'b0;
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          psum_q <= lane_sum;
          acc_q  <= acc_q + psum_q;
          w_sh   <= w_sh >> (LANES*DATA_WIDTH);
          x_sh   <= x_sh >> (LANES*DATA_WIDTH);
          pass_q <= pass_q + PC_W'(1);
          if (pass_q == PC_W'(PASSES)) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (ACTIVATION == int'(ACT_RELU)
              && rs_data[DATA_WIDTH-1]) begin
            data_o <= '0;
          end else begin
            data_o <= rs_data;
          end
          sat_o     <= rs_sat;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_perceptron_seq.sv
// Directed bench: LANES=4 identity, LANES=4 ReLU and
// LANES=11 identity instances share one stimulus bus.
module tb_nn_perceptron_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [10:0][15:0]  wts;
  logic [10:0][15:0]  xin;
  logic [15:0]        bias;
  logic               in_valid;
  logic               out_ready;

  logic        ir_m, ov_m, s_m;
  logic [15:0] d_m;
  logic        ir_r, ov_r, s_r;
  logic [15:0] d_r;
  logic        ir_f, ov_f, s_f;
  logic [15:0] d_f;

  int checks = 0;
  int passes = 0;
  int lat_m, lat_r, lat_f;
  logic [15:0] dm, dr, df;
  logic sm, sr, sf;

  always #5 clk = ~clk;

  nn_perceptron_seq #(
    .FEATURES(11), .LANES(4), .ACTIVATION(0)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .weights(wts), .bias(bias),
    .in_valid(in_valid), .in_ready(ir_m), .data_i(xin),
    .out_valid(ov_m), .out_ready(out_ready),
    .data_o(d_m), .sat_o(s_m)
  );

  nn_perceptron_seq #(
    .FEATURES(11), .LANES(4), .ACTIVATION(1)
  ) u_relu (
    .clk(clk), .rst_n(rst_n), .weights(wts), .bias(bias),
    .in_valid(in_valid), .in_ready(ir_r), .data_i(xin),
    .out_valid(ov_r), .out_ready(out_ready),
    .data_o(d_r), .sat_o(s_r)
  );

  nn_perceptron_seq #(
    .FEATURES(11), .LANES(11), .ACTIVATION(0)
  ) u_full (
    .clk(clk), .rst_n(rst_n), .weights(wts), .bias(bias),
    .in_valid(in_valid), .in_ready(ir_f), .data_i(xin),
    .out_valid(ov_f), .out_ready(out_ready),
    .data_o(d_f), .sat_o(s_f)
  );

  task automatic set_all(input logic [15:0] w,
                         input logic [15:0] x,
                         input logic [15:0] b);
    for (int i = 0; i < 11; i++) begin
      wts[i] = w;
      xin[i] = x;
    end
    bias = b;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ir_m && ir_r && ir_f) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec();
    wait_idle();
    lat_m = 0; lat_r = 0; lat_f = 0;
    dm = '0; dr = '0; df = '0;
    sm = 1'b0; sr = 1'b0; sf = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wts[i] = 16'($urandom);
      xin[i] = 16'($urandom);
    end
    bias = 16'($urandom);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (ov_m && lat_m == 0) begin
        lat_m = e; dm = d_m; sm = s_m;
      end
      if (ov_r && lat_r == 0) begin
        lat_r = e; dr = d_r; sr = s_r;
      end
      if (ov_f && lat_f == 0) begin
        lat_f = e; df = d_f; sf = s_f;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_all(16'h0, 16'h0, 16'h0);
    #12;
    checks++; if (ir_m !== 1'b1) $display("FAIL rst_in_ready got %b want 1", ir_m); else passes++;
    checks++; if (ov_m !== 1'b0) $display("FAIL rst_out_valid got %b want 0", ov_m); else passes++;
    checks++; if (d_m !== 16'h0) $display("FAIL rst_data got %h want 0000", d_m); else passes++;
    checks++; if (s_m !== 1'b0) $display("FAIL rst_sat got %b want 0", s_m); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_all(16'h0100, 16'h0100, 16'h0000);
    run_vec();
    checks++; if (lat_m !== 5) $display("FAIL ones_latency got %0d want 5", lat_m); else passes++;
    checks++; if (dm !== 16'h0B00) $display("FAIL ones_data got %h want 0b00", dm); else passes++;
    checks++; if (sm !== 1'b0) $display("FAIL ones_sat got %b want 0", sm); else passes++;
    checks++; if (dr !== 16'h0B00) $display("FAIL ones_relu got %h want 0b00", dr); else passes++;
    checks++; if (lat_f !== 3) $display("FAIL full_latency got %0d want 3", lat_f); else passes++;
    checks++; if (df !== 16'h0B00) $display("FAIL full_data got %h want 0b00", df); else passes++;
    // 0.5*(1+..+10) - 11 = 16.5; feature 10 sits in the padded pass
    for (int i = 0; i < 11; i++) begin
      wts[i] = 16'((i + 1) * 256);
      xin[i] = 16'h0080;
    end
    xin[10] = 16'hFF00;
    bias = 16'h0000;
    run_vec();
    checks++; if (dm !== 16'h1080) $display("FAIL ramp_data got %h want 1080", dm); else passes++;
    checks++; if (df !== 16'h1080) $display("FAIL ramp_full got %h want 1080", df); else passes++;
  endtask

  task automatic test_saturation();
    set_all(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_vec();
    checks++; if (dm !== 16'h7FFF) $display("FAIL satpos_data got %h want 7fff", dm); else passes++;
    checks++; if (sm !== 1'b1) $display("FAIL satpos_flag got %b want 1", sm); else passes++;
    checks++; if (dr !== 16'h7FFF) $display("FAIL satpos_relu got %h want 7fff", dr); else passes++;
    checks++; if (sf !== 1'b1) $display("FAIL satpos_full got %b want 1", sf); else passes++;
    set_all(16'h8000, 16'h7FFF, 16'h0000);
    run_vec();
    checks++; if (dm !== 16'h8000) $display("FAIL satneg_data got %h want 8000", dm); else passes++;
    checks++; if (sm !== 1'b1) $display("FAIL satneg_flag got %b want 1", sm); else passes++;
    checks++; if (dr !== 16'h0000) $display("FAIL satneg_relu got %h want 0000", dr); else passes++;
    checks++; if (sr !== 1'b1) $display("FAIL satneg_relu_flag got %b want 1", sr); else passes++;
  endtask

  task automatic test_relu();
    set_all(16'hFF00, 16'h0100, 16'h0000);
    run_vec();
    checks++; if (dm !== 16'hF500) $display("FAIL neg_data got %h want f500", dm); else passes++;
    checks++; if (sm !== 1'b0) $display("FAIL neg_sat got %b want 0", sm); else passes++;
    checks++; if (dr !== 16'h0000) $display("FAIL relu_data got %h want 0000", dr); else passes++;
    checks++; if (sr !== 1'b0) $display("FAIL relu_sat got %b want 0", sr); else passes++;
    checks++; if (df !== 16'hF500) $display("FAIL neg_full got %h want f500", df); else passes++;
  endtask

  task automatic test_rounding();
    logic [15:0] w_tab [4];
    logic [15:0] b_tab [4];
    logic [15:0] e_tab [4];
    w_tab = '{16'h0080, 16'h0040, 16'hFF80, 16'h0000};
    b_tab = '{16'h0000, 16'h0000, 16'h0000, 16'h0100};
    e_tab = '{16'h0001, 16'h0000, 16'h0000, 16'h0100};
    for (int k = 0; k < 4; k++) begin
      set_all(16'h0000, 16'h0000, b_tab[k]);
      wts[0] = w_tab[k];
      xin[0] = 16'h0001;
      run_vec();
      checks++; if (dm !== e_tab[k]) $display("FAIL round%0d got %h want %h", k, dm, e_tab[k]); else passes++;
      checks++; if (df !== e_tab[k]) $display("FAIL round%0d_full got %h want %h", k, df, e_tab[k]); else passes++;
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int extra = 0;
    set_all(16'h0100, 16'h0100, 16'h0000);
    wait_idle();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!ov_m && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 5) $display("FAIL bp_latency got %0d want 5", n); else passes++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      xin[0] = 16'h0200;
      @(posedge clk); #1;
      checks++;
      if (ov_m !== 1'b1 || d_m !== 16'h0B00 || ir_m !== 1'b0)
        $display("FAIL bp_hold%0d got v=%b d=%h r=%b want v=1 d=0b00 r=0",
                 k, ov_m, d_m, ir_m);
      else passes++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov_m !== 1'b0) $display("FAIL bp_release_valid got %b want 0", ov_m); else passes++;
    checks++; if (ir_m !== 1'b1) $display("FAIL bp_release_ready got %b want 1", ir_m); else passes++;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ov_m) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL bp_ignored got %0d pulses want 0", extra); else passes++;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    set_all(16'h0100, 16'h0100, 16'h0000);
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov_m !== 1'b0) $display("FAIL midrst_valid got %b want 0", ov_m); else passes++;
    checks++; if (d_m !== 16'h0) $display("FAIL midrst_data got %h want 0000", d_m); else passes++;
    checks++; if (ir_m !== 1'b1) $display("FAIL midrst_ready got %b want 1", ir_m); else passes++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ov_m || ov_r || ov_f) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL midrst_stale got %0d pulses want 0", stray); else passes++;
    checks++; if (ir_m !== 1'b1) $display("FAIL midrst_idle got %b want 1", ir_m); else passes++;
    set_all(16'h0100, 16'h0100, 16'h0000);
    run_vec();
    checks++; if (lat_m !== 5) $display("FAIL after_rst_lat got %0d want 5", lat_m); else passes++;
    checks++; if (dm !== 16'h0B00) $display("FAIL after_rst_data got %h want 0b00", dm); else passes++;
    checks++; if (lat_f !== 3) $display("FAIL after_rst_full_lat got %0d want 3", lat_f); else passes++;
    checks++; if (df !== 16'h0B00) $display("FAIL after_rst_full got %h want 0b00", df); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
